frame_packetizer: RTL and testbench

FRAME_PACKETIZER -- requirements
Module: frame_packetizer

---
 rtl/frame_pkg.sv | 25 ++
 rtl/frame_packetizer.sv | 187 ++++++++++++++++++
 tb/tb_frame_packetizer.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_pkg.sv
// Shared types and constants for the frame packetizer.
// FRAME_CHECKSUM_EN adds the S_CSUM trailer state.
package frame_pkg;

    localparam int LEN_W = 16;

    localparam logic [7:0] SYNC0 = 8'hA5;
    localparam logic [7:0] SYNC1 = 8'h5A;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SYNC0,
        S_SYNC1,
        S_FNUM,
        S_PAYLOAD,
        S_DRAIN,
        S_LEN_LO,
        S_LEN_HI,
`ifdef FRAME_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE
    } state_t;

endpackage

// File: rtl/frame_packetizer.sv
// Wraps a byte stream into A5 5A fnum payload len_lo len_hi [csum] frames.
// Optional checksum trailer enabled by FRAME_CHECKSUM_EN.
module frame_packetizer
    import frame_pkg::*;
#(
    parameter logic [LEN_W-1:0] MAX_BYTES = 16'd19200
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       busy,
    output logic       done,
    output logic       truncated,
    output logic [7:0] frame_cnt
);

    state_t state_q, state_d;

    logic [7:0]       m_data_q, m_data_d;
    logic             m_valid_q, m_valid_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             trunc_q, trunc_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             lo_ld_q, lo_ld_d;
`ifdef FRAME_CHECKSUM_EN
    logic [7:0]       csum_q, csum_d;
`endif

    logic xfer;
    logic can_load;
    logic acc;

    assign xfer     = m_valid_q & m_ready;
    assign can_load = ~m_valid_q | m_ready;
    assign acc      = s_valid & s_ready;

    always_comb begin
        state_d   = state_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        len_d     = len_q;
        trunc_d   = trunc_q;
        cnt_d     = cnt_q;
        lo_ld_d   = lo_ld_q;
`ifdef FRAME_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        s_ready   = 1'b0;
        done      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_SYNC0;
                    m_data_d  = SYNC0;
                    m_valid_d = 1'b1;
                    len_d     = '0;
                    trunc_d   = 1'b0;
                    lo_ld_d   = 1'b0;
`ifdef FRAME_CHECKSUM_EN
                    csum_d    = cnt_q;
`endif
                end
            end
            S_SYNC0: begin
                if (xfer) begin
                    m_data_d = SYNC1;
                    state_d  = S_SYNC1;
                end
            end
            S_SYNC1: begin
                if (xfer) begin
                    m_data_d = cnt_q;
                    state_d  = S_FNUM;
                end
            end
            S_FNUM: begin
                if (xfer) begin
                    m_valid_d = 1'b0;
                    state_d   = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                s_ready = can_load;
                if (xfer) m_valid_d = 1'b0;
                if (acc) begin
                    m_data_d  = s_data;
                    m_valid_d = 1'b1;
                    len_d     = len_q + 16'd1;
`ifdef FRAME_CHECKSUM_EN
                    csum_d    = csum_q + s_data;
`endif
                    if (s_last) begin
                        state_d = S_LEN_LO;
                    end else if (len_q + 16'd1 == MAX_BYTES) begin
                        trunc_d = 1'b1;
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                s_ready = 1'b1;
                if (xfer) m_valid_d = 1'b0;
                if (s_valid && s_last) state_d = S_LEN_LO;
            end
            // Last payload byte may still be pending; load len_lo once free.
            S_LEN_LO: begin
                if (!lo_ld_q) begin
                    if (can_load) begin
                        m_data_d  = len_q[7:0];
                        m_valid_d = 1'b1;
                        lo_ld_d   = 1'b1;
                    end
                end else if (xfer) begin
                    m_data_d = len_q[15:8];
                    lo_ld_d  = 1'b0;
                    state_d  = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
`ifdef FRAME_CHECKSUM_EN
                    m_data_d = csum_q + len_q[7:0] + len_q[15:8];
                    state_d  = S_CSUM;
`else
                    m_valid_d = 1'b0;
                    state_d   = S_DONE;
`endif
                end
            end
`ifdef FRAME_CHECKSUM_EN
            S_CSUM: begin
                if (xfer) begin
                    m_valid_d = 1'b0;
                    state_d   = S_DONE;
                end
            end
`endif
            S_DONE: begin
                done    = 1'b1;
                cnt_d   = cnt_q + 8'd1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            len_q     <= '0;
            trunc_q   <= 1'b0;
            cnt_q     <= '0;
            lo_ld_q   <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            len_q     <= len_d;
            trunc_q   <= trunc_d;
            cnt_q     <= cnt_d;
            lo_ld_q   <= lo_ld_d;
`ifdef FRAME_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

    assign m_data    = m_data_q;
    assign m_valid   = m_valid_q;
    assign busy      = (state_q != S_IDLE);
    assign truncated = trunc_q;
    assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_frame_packetizer.sv
// Directed bench for frame_packetizer (MAX_BYTES=4).
// Expected bytes follow FRAME_CHECKSUM_EN when it is defined.
module tb_frame_packetizer;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       busy;
    logic       done;
    logic       truncated;
    logic [7:0] frame_cnt;

    int errors = 0;
    int checks = 0;

    logic [7:0] src_q[$];
    logic [7:0] got[$];
    int done_n;
    int stall_bad;
    int acc_n;

    frame_packetizer #(.MAX_BYTES(16'd4)) dut (
        .clk(clk),
        .resetn(resetn),
        .start(start),
        .s_data(s_data),
        .s_valid(s_valid),
        .s_last(s_last),
        .s_ready(s_ready),
        .m_data(m_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .busy(busy),
        .done(done),
        .truncated(truncated),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic run_frame(input int stall, input int start_mid,
                             input int abort_at);
        int idx = 0;
        bit pst = 1'b0;
        bit fin = 1'b0;
        logic [7:0] pd = 8'h00;
        got.delete();
        done_n = 0;
        stall_bad = 0;
        acc_n = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            start = (cyc == 0) || (start_mid != 0 && idx == 1);
            m_ready = (stall != 0) ? (cyc % 3 == 0) : 1'b1;
            s_valid = (idx < src_q.size());
            s_data = s_valid ? src_q[idx] : 8'h00;
            s_last = s_valid && (idx == src_q.size() - 1);
            @(negedge clk);
            if (pst && (!m_valid || m_data !== pd)) stall_bad++;
            pst = m_valid && !m_ready;
            pd = m_data;
            if (m_valid && m_ready) got.push_back(m_data);
            if (s_valid && s_ready) begin
                idx++;
                acc_n++;
            end
            if (done) done_n++;
            fin = done || (abort_at > 0 && idx == abort_at);
            @(posedge clk);
            #1;
            if (fin) break;
        end
        start = 1'b0;
        s_valid = 1'b0;
        s_last = 1'b0;
        s_data = 8'h00;
        m_ready = 1'b1;
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL timeout: frame not finished, got %0d bytes", got.size());
        end
    endtask

    task automatic test_reset();
        checks += 7;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
        if (m_data !== 8'h00) begin errors++; $display("FAIL rst_m_data: got %h want 00", m_data); end
        if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready: got %b want 0", s_ready); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
        if (truncated !== 1'b0) begin errors++; $display("FAIL rst_trunc: got %b want 0", truncated); end
        if (frame_cnt !== 8'h00) begin errors++; $display("FAIL rst_cnt: got %h want 00", frame_cnt); end
    endtask

    task automatic test_basic();
        logic [7:0] e[$];
        e = '{8'hA5, 8'h5A, 8'h00, 8'h01, 8'h02, 8'h03, 8'h03, 8'h00};
`ifdef FRAME_CHECKSUM_EN
        e.push_back(8'h09);
`endif
        src_q = '{8'h01, 8'h02, 8'h03};
        run_frame(0, 0, 0);
        checks++;
        if (got.size() != e.size()) begin errors++; $display("FAIL basic_len: got %0d want %0d", got.size(), e.size()); end
        for (int i = 0; i < e.size(); i++) begin
            checks++;
            if (i >= got.size() || got[i] !== e[i]) begin
                errors++;
                $display("FAIL basic_byte%0d: got %h want %h", i, (i < got.size()) ? got[i] : 8'hxx, e[i]);
            end
        end
        checks += 4;
        if (done_n != 1) begin errors++; $display("FAIL basic_done: got %0d want 1", done_n); end
        if (frame_cnt !== 8'h01) begin errors++; $display("FAIL basic_cnt: got %h want 01", frame_cnt); end
        if (truncated !== 1'b0) begin errors++; $display("FAIL basic_trunc: got %b want 0", truncated); end
        if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b want 0", busy); end
    endtask

    task automatic test_stall();
        logic [7:0] e[$];
        e = '{8'hA5, 8'h5A, 8'h01, 8'h01, 8'h02, 8'h03, 8'h03, 8'h00};
`ifdef FRAME_CHECKSUM_EN
        e.push_back(8'h0A);
`endif
        src_q = '{8'h01, 8'h02, 8'h03};
        run_frame(1, 0, 0);
        checks++;
        if (got.size() != e.size()) begin errors++; $display("FAIL stall_len: got %0d want %0d", got.size(), e.size()); end
        for (int i = 0; i < e.size(); i++) begin
            checks++;
            if (i >= got.size() || got[i] !== e[i]) begin
                errors++;
                $display("FAIL stall_byte%0d: got %h want %h", i, (i < got.size()) ? got[i] : 8'hxx, e[i]);
            end
        end
        checks += 2;
        if (stall_bad != 0) begin errors++; $display("FAIL stall_hold: %0d unstable cycles, want 0", stall_bad); end
        if (frame_cnt !== 8'h02) begin errors++; $display("FAIL stall_cnt: got %h want 02", frame_cnt); end
    endtask

    task automatic test_truncate();
        logic [7:0] e[$];
        e = '{8'hA5, 8'h5A, 8'h02, 8'h10, 8'h11, 8'h12, 8'h13, 8'h04, 8'h00};
`ifdef FRAME_CHECKSUM_EN
        e.push_back(8'h4C);
`endif
        src_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
        run_frame(0, 0, 0);
        checks++;
        if (got.size() != e.size()) begin errors++; $display("FAIL trunc_len: got %0d want %0d", got.size(), e.size()); end
        for (int i = 0; i < e.size(); i++) begin
            checks++;
            if (i >= got.size() || got[i] !== e[i]) begin
                errors++;
                $display("FAIL trunc_byte%0d: got %h want %h", i, (i < got.size()) ? got[i] : 8'hxx, e[i]);
            end
        end
        checks += 3;
        if (truncated !== 1'b1) begin errors++; $display("FAIL trunc_flag: got %b want 1", truncated); end
        if (acc_n != 6) begin errors++; $display("FAIL trunc_acc: got %0d want 6", acc_n); end
        if (done_n != 1) begin errors++; $display("FAIL trunc_done: got %0d want 1", done_n); end
    endtask

    task automatic test_exact_max();
        logic [7:0] e[$];
        e = '{8'hA5, 8'h5A, 8'h03, 8'h20, 8'h21, 8'h22, 8'h23, 8'h04, 8'h00};
`ifdef FRAME_CHECKSUM_EN
        e.push_back(8'h8D);
`endif
        src_q = '{8'h20, 8'h21, 8'h22, 8'h23};
        run_frame(0, 0, 0);
        checks++;
        if (got.size() != e.size()) begin errors++; $display("FAIL exact_len: got %0d want %0d", got.size(), e.size()); end
        for (int i = 0; i < e.size(); i++) begin
            checks++;
            if (i >= got.size() || got[i] !== e[i]) begin
                errors++;
                $display("FAIL exact_byte%0d: got %h want %h", i, (i < got.size()) ? got[i] : 8'hxx, e[i]);
            end
        end
        checks += 2;
        if (truncated !== 1'b0) begin errors++; $display("FAIL exact_trunc: got %b want 0", truncated); end
        if (frame_cnt !== 8'h04) begin errors++; $display("FAIL exact_cnt: got %h want 04", frame_cnt); end
    endtask

    task automatic test_start_ignored();
        logic [7:0] e[$];
        e = '{8'hA5, 8'h5A, 8'h04, 8'h01, 8'h02, 8'h03, 8'h03, 8'h00};
`ifdef FRAME_CHECKSUM_EN
        e.push_back(8'h0D);
`endif
        src_q = '{8'h01, 8'h02, 8'h03};
        run_frame(0, 1, 0);
        checks++;
        if (got.size() != e.size()) begin errors++; $display("FAIL restart_len: got %0d want %0d", got.size(), e.size()); end
        for (int i = 0; i < e.size(); i++) begin
            checks++;
            if (i >= got.size() || got[i] !== e[i]) begin
                errors++;
                $display("FAIL restart_byte%0d: got %h want %h", i, (i < got.size()) ? got[i] : 8'hxx, e[i]);
            end
        end
        repeat (10) @(posedge clk);
        #1;
        checks += 3;
        if (busy !== 1'b0) begin errors++; $display("FAIL restart_busy: got %b want 0", busy); end
        if (m_valid !== 1'b0) begin errors++; $display("FAIL restart_mvalid: got %b want 0", m_valid); end
        if (frame_cnt !== 8'h05) begin errors++; $display("FAIL restart_cnt: got %h want 05", frame_cnt); end
    endtask

    task automatic test_minimal();
        logic [7:0] e[$];
        e = '{8'hA5, 8'h5A, 8'h05, 8'h7F, 8'h01, 8'h00};
`ifdef FRAME_CHECKSUM_EN
        e.push_back(8'h85);
`endif
        src_q = '{8'h7F};
        run_frame(0, 0, 0);
        checks++;
        if (got.size() != e.size()) begin errors++; $display("FAIL min_len: got %0d want %0d", got.size(), e.size()); end
        for (int i = 0; i < e.size(); i++) begin
            checks++;
            if (i >= got.size() || got[i] !== e[i]) begin
                errors++;
                $display("FAIL min_byte%0d: got %h want %h", i, (i < got.size()) ? got[i] : 8'hxx, e[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] e[$];
        src_q = '{8'h01, 8'h02, 8'h03};
        run_frame(0, 0, 2);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_pre: got %b want 1", busy); end
        resetn = 1'b0;
        #1;
        checks += 6;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL mid_m_valid: got %b want 0", m_valid); end
        if (m_data !== 8'h00) begin errors++; $display("FAIL mid_m_data: got %h want 00", m_data); end
        if (s_ready !== 1'b0) begin errors++; $display("FAIL mid_s_ready: got %b want 0", s_ready); end
        if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
        if (truncated !== 1'b0) begin errors++; $display("FAIL mid_trunc: got %b want 0", truncated); end
        if (frame_cnt !== 8'h00) begin errors++; $display("FAIL mid_cnt: got %h want 00", frame_cnt); end
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        e = '{8'hA5, 8'h5A, 8'h00, 8'h01, 8'h02, 8'h03, 8'h03, 8'h00};
`ifdef FRAME_CHECKSUM_EN
        e.push_back(8'h09);
`endif
        run_frame(0, 0, 0);
        checks++;
        if (got.size() != e.size()) begin errors++; $display("FAIL mid_len: got %0d want %0d", got.size(), e.size()); end
        for (int i = 0; i < e.size(); i++) begin
            checks++;
            if (i >= got.size() || got[i] !== e[i]) begin
                errors++;
                $display("FAIL mid_byte%0d: got %h want %h", i, (i < got.size()) ? got[i] : 8'hxx, e[i]);
            end
        end
    endtask

    initial begin
        resetn = 1'b0;
        start = 1'b0;
        s_data = 8'h00;
        s_valid = 1'b0;
        s_last = 1'b0;
        m_ready = 1'b1;
        #12;
        test_reset();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        test_basic();
        test_stall();
        test_truncate();
        test_exact_max();
        test_start_ignored();
        test_minimal();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
